// File: rtl/clock_tick_sched_if.sv
// Control and status bundle between the start-strobe scheduler and its user.
interface clock_tick_sched_if #(
  parameter int PEND_W = 3
);
  logic              run;
  logic              step;
  logic              start_200ms;
  logic              start_odd;
  logic              start_400ms;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overrun;

  modport master (
    output run, step,
    input  start_200ms, start_odd, start_400ms, busy, pending, overrun
  );

  modport slave (
    input  run, step,
    output start_200ms, start_odd, start_400ms, busy, pending, overrun
  );
endinterface

// File: rtl/clock_tick_sched.sv
// Prescaled 200 ms tick scheduler issuing guarded start strobes for the clock render path.
// Optional `CLOCK_TICK_SCHED_STEP_EN: when defined, bus.step injects manual advance events.
module clock_tick_sched #(
  parameter int TICK_CYCLES  = 5000000,
  parameter int GUARD_CYCLES = 2800,
  parameter int PEND_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  clock_tick_sched_if.slave bus
);
  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int SUM_W = PEND_W + 2;
  localparam logic [CNT_W-1:0]  TICK_LAST  = CNT_W'(TICK_CYCLES - 1);
  localparam logic [GRD_W-1:0]  GUARD_LOAD = GRD_W'(GUARD_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX   = '1;

  typedef enum logic {IDLE, GUARD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [2:0]        phase_q;
  logic [GRD_W-1:0]  guard_q, guard_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              redraw_q, redraw_d;
  logic              parity_q;
  logic              overrun_q;
  logic              start_200ms_q, start_odd_q, start_400ms_q;
  logic              tick, tick_adv, tick_redraw, step_adv;
  logic [1:0]        arrivals;
  logic              issue_adv, issue_redraw, pend_full;
  logic [SUM_W-1:0]  pend_sum;

  assign tick        = bus.run && (count_q == TICK_LAST);
  assign tick_adv    = tick && (phase_q == 3'd0);
  assign tick_redraw = tick && (phase_q == 3'd2);

`ifdef CLOCK_TICK_SCHED_STEP_EN
  assign step_adv = bus.step;
`else
  logic step_unused;
  assign step_unused = bus.step;
  assign step_adv    = 1'b0;
`endif

  assign arrivals = {1'b0, tick_adv} + {1'b0, step_adv};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      phase_q <= 3'd0;
    end else if (bus.run) begin
      if (tick) begin
        count_q <= '0;
        phase_q <= (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Queued advances win over a pending redraw; the queue sum includes same-cycle arrivals.
  always_comb begin
    state_d      = state_q;
    guard_d      = guard_q;
    issue_adv    = 1'b0;
    issue_redraw = 1'b0;
    case (state_q)
      IDLE: begin
        if ((pending_q != '0) || (arrivals != 2'd0)) begin
          issue_adv = 1'b1;
          guard_d   = GUARD_LOAD;
          state_d   = GUARD;
        end else if (redraw_q || tick_redraw) begin
          issue_redraw = 1'b1;
          guard_d      = GUARD_LOAD;
          state_d      = GUARD;
        end
      end
      GUARD: begin
        if (guard_q == '0) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q - GRD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_sum  = SUM_W'(pending_q) + SUM_W'(arrivals) - SUM_W'(issue_adv);
    pend_full = pend_sum > SUM_W'(PEND_MAX);
    pending_d = pend_full ? PEND_MAX : pend_sum[PEND_W-1:0];
    redraw_d  = (issue_adv || issue_redraw) ? 1'b0 : (redraw_q || tick_redraw);
  end

  // Redraw flag comes out of reset set so the display gets an initial draw.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      guard_q       <= '0;
      pending_q     <= '0;
      redraw_q      <= 1'b1;
      parity_q      <= 1'b0;
      overrun_q     <= 1'b0;
      start_200ms_q <= 1'b0;
      start_odd_q   <= 1'b0;
      start_400ms_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      guard_q       <= guard_d;
      pending_q     <= pending_d;
      redraw_q      <= redraw_d;
      overrun_q     <= overrun_q | pend_full;
      start_200ms_q <= issue_adv & ~parity_q;
      start_odd_q   <= issue_adv & parity_q;
      start_400ms_q <= issue_redraw;
      if (issue_adv) begin
        parity_q <= ~parity_q;
      end
    end
  end

  assign bus.start_200ms = start_200ms_q;
  assign bus.start_odd   = start_odd_q;
  assign bus.start_400ms = start_400ms_q;
  assign bus.busy        = (state_q == GUARD);
  assign bus.pending     = pending_q;
  assign bus.overrun     = overrun_q;
endmodule
